multicycle_control_unit: RTL
============================

# multicycle_control_unit

Parametrised multi-cycle successor to the single-cycle MIPS main decoder. A Moore FSM steps each instruction through fetch, decode, execute, memory and write-back states, producing per-cycle datapath controls for a shared-ALU, single-memory datapath. Memory states stall on a `mem_ready` handshake, bounded by a wait-cycle timeout. Sits between the instruction register opcode field and the multi-cycle datapath; the existing ALU control decoder consumes `alu_op`.

## Interface
- `OPCODE_W`, 6: opcode field width.
- `WAIT_LIMIT`, 16: max consecutive `mem_ready`-low cycles in one memory state before timeout; legal range is 1..255.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `opcode` in OPCODE_W: IR[31:26]; sampled only in DECODE.
- `mem_ready` in 1: memory access completes in the cycle it is high.
- `pc_write`, `pc_write_cond`, `iord`, `mem_read`, `mem_write`, `ir_write` out 1: PC and memory controls.
- `reg_dst`, `mem_to_reg`, `reg_write`, `alu_src_a` out 1: register-file and ALU-A controls.
- `alu_src_b` out 2: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = immediate<<2.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = funct.
- `pc_source` out 2: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `branch_ne` out 1: inverts the zero condition for `pc_write_cond`.
- `state` out 4: current state encoding, for debug.
- `instr_done` out 1: one-cycle pulse in an instruction's final state.
- `illegal_op`, `timeout` out 1: one-cycle error pulses.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11, TRAP 12.
- FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00. `ir_write` and `pc_write` equal `mem_ready`. Advances to DECODE when `mem_ready`=1.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00. Dispatches on opcode:
  - 000000 to R_EXEC.
  - 100011 or 101011 to MEM_ADDR.
  - 000100 to BRANCH.
  - 000010 to JUMP.
  - 001000 to ADDI_EXEC.
  - Any other opcode to TRAP.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_read`=1, `iord`=1. Goes to MEM_WB on `mem_ready`.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0; returns to FETCH.
- MEM_WR: `mem_write`=1, `iord`=1. Returns to FETCH on `mem_ready`.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Goes to R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0; returns to FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01. Returns to FETCH.
- JUMP: `pc_write`=1, `pc_source`=10. Returns to FETCH.
- ADDI_EXEC: same controls as MEM_ADDR. Goes to ADDI_WB.
- ADDI_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0; returns to FETCH.
- TRAP: `illegal_op`=1 (or `timeout`=1, per the trap cause latched on entry). No other control asserted. Returns to FETCH.
- Any output not listed for a state is 0. No X outputs in any state.
- Wait counter (8-bit):
  - Increments each cycle `mem_ready`=0 in FETCH, MEM_RD or MEM_WR.
  - Clears on every state change.
  - When the counter reaches WAIT_LIMIT with `mem_ready` still 0, the next state is TRAP with cause timeout.
  - `mem_read`/`mem_write` are held throughout the wait.

## Timing
- Reset: state is FETCH, counter is 0, trap cause is cleared. While `rst_n`=0, all outputs are 0, including FETCH's. Reset asserted mid-instruction aborts it at the next edge.
- Cycles per instruction with zero-wait memory:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
- Each memory-wait cycle adds 1.
- `instr_done` is high in MEM_WB, MEM_WR (when `mem_ready`=1), R_WB, BRANCH, JUMP and ADDI_WB.
- Timeout: TRAP is entered exactly WAIT_LIMIT+1 cycles after entering a memory state with `mem_ready` held low.
- If `mem_ready` rises in the limit cycle itself, the access completes normally and no timeout occurs.

## Configuration
- `MCU_BNE_EN` defined: opcode 000101 dispatches to BRANCH with `branch_ne`=1.
- `MCU_BNE_EN` undefined: 000101 goes to TRAP, and `branch_ne` is tied to 0.

## Structure
- Package `mcu_pkg` holds:
  - state enum and its encodings
  - opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_BNE`, `OP_J`, `OP_ADDI`)
  - `alu_src_b`, `alu_op` and `pc_source` encodings
- One sub-module, `mcu_wait_timer`, implements the wait counter and timeout compare.

## Test plan
- Reset held 3 cycles, then released with `mem_ready`=1 and opcode 000000: state sequence 0,1,6,7,0; `reg_dst`=1 in R_WB; all outputs 0 during reset.
- lw (100011) with `mem_ready` low for 2 cycles in MEM_RD: 7 cycles total; `iord`=1 throughout MEM_RD; `mem_to_reg`=1 in MEM_WB.
- beq (000100): BRANCH shows `alu_op`=01, `pc_write_cond`=1, `pc_source`=01; `instr_done` pulses; next state is FETCH.
- Opcode 111111: TRAP, `illegal_op` high for 1 cycle, then FETCH. Opcode 000101 behaves the same unless `MCU_BNE_EN` is defined, in which case BRANCH asserts `branch_ne`=1.
- WAIT_LIMIT=4 with `mem_ready` stuck low in MEM_WR: TRAP and `timeout` pulse 5 cycles after MEM_WR entry. Variant with `mem_ready` rising on the 5th cycle: no timeout.
- `rst_n` low during MEM_WB: `reg_write` is 0 in the reset cycle and state is FETCH afterwards.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mcu_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  typedef enum logic {
    CAUSE_ILLEGAL = 1'b0,
    CAUSE_TIMEOUT = 1'b1
  } trap_cause_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       branch_ne;
    logic       instr_done;
    logic       illegal_op;
    logic       timeout;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle: opcode/mem_ready in, per-cycle controls out.
interface multicycle_control_unit_if
  import mcu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                iord;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic [1:0]          pc_source;
  logic                branch_ne;
  logic [STATE_W-1:0]  state;
  logic                instr_done;
  logic                illegal_op;
  logic                timeout;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, branch_ne, state, instr_done, illegal_op, timeout
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, branch_ne, state, instr_done, illegal_op, timeout
  );
endinterface

// File: rtl/mcu_wait_timer.sv
// Memory-wait counter: counts stalled cycles in a memory state and flags the
// cycle in which the wait limit is reached with the access still pending.
module mcu_wait_timer
  import mcu_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_wait,
  input  logic i_advance,
  output logic o_timeout_c
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_advance) begin
      r_count <= '0;
    end else if (i_wait) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_timeout_c = i_wait && (r_count == CNT_W'(WAIT_LIMIT));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS main control FSM with mem_ready stalls and wait timeout.
// Optional MCU_BNE_EN: decodes bne into the BRANCH state with branch_ne set.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int unsigned OPCODE_W   = 6,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  multicycle_control_unit_if.master  bus
);

  state_e      r_state;
  state_e      w_next;
  trap_cause_e r_trap_cause;
  trap_cause_e w_cause;
  logic        r_is_sw;
  logic        w_dec_sw;
  ctrl_t       w_ctrl;
  ctrl_t       w_out;
  logic        w_mem_wait;
  logic        w_advance;
  logic        w_timeout_c;
`ifdef MCU_BNE_EN
  logic        r_is_bne;
  logic        w_dec_bne;
`endif

  assign w_mem_wait = ((r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                       (r_state == S_MEM_WR)) && !bus.mem_ready;
  assign w_advance  = (w_next != r_state);

  mcu_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wait      (w_mem_wait),
    .i_advance   (w_advance),
    .o_timeout_c (w_timeout_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Opcode class and trap cause are captured once so later states need no opcode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_trap_cause <= CAUSE_ILLEGAL;
      r_is_sw      <= 1'b0;
`ifdef MCU_BNE_EN
      r_is_bne     <= 1'b0;
`endif
    end else begin
      if (w_next == S_TRAP) begin
        r_trap_cause <= w_cause;
      end
      r_is_sw  <= w_dec_sw;
`ifdef MCU_BNE_EN
      r_is_bne <= w_dec_bne;
`endif
    end
  end

  always_comb begin
    w_next   = r_state;
    w_ctrl   = '0;
    w_cause  = CAUSE_ILLEGAL;
    w_dec_sw = r_is_sw;
`ifdef MCU_BNE_EN
    w_dec_bne = r_is_bne;
`endif
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.iord      = 1'b0;
        w_ctrl.alu_src_a = 1'b0;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.alu_op    = ALU_ADD;
        w_ctrl.pc_source = PCSRC_ALU;
        w_ctrl.ir_write  = bus.mem_ready;
        w_ctrl.pc_write  = bus.mem_ready;
        if (bus.mem_ready) begin
          w_next = S_DECODE;
        end else if (w_timeout_c) begin
          w_next  = S_TRAP;
          w_cause = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        w_ctrl.alu_src_a = 1'b0;
        w_ctrl.alu_src_b = SRCB_IMM_SL2;
        w_ctrl.alu_op    = ALU_ADD;
        w_dec_sw         = 1'b0;
`ifdef MCU_BNE_EN
        w_dec_bne        = 1'b0;
`endif
        if (bus.opcode == OPCODE_W'(OP_RTYPE)) begin
          w_next = S_R_EXEC;
        end else if (bus.opcode == OPCODE_W'(OP_LW)) begin
          w_next = S_MEM_ADDR;
        end else if (bus.opcode == OPCODE_W'(OP_SW)) begin
          w_next   = S_MEM_ADDR;
          w_dec_sw = 1'b1;
        end else if (bus.opcode == OPCODE_W'(OP_BEQ)) begin
          w_next = S_BRANCH;
`ifdef MCU_BNE_EN
        end else if (bus.opcode == OPCODE_W'(OP_BNE)) begin
          w_next    = S_BRANCH;
          w_dec_bne = 1'b1;
`else
        end else if (bus.opcode == OPCODE_W'(OP_BNE)) begin
          w_next = S_TRAP;
`endif
        end else if (bus.opcode == OPCODE_W'(OP_J)) begin
          w_next = S_JUMP;
        end else if (bus.opcode == OPCODE_W'(OP_ADDI)) begin
          w_next = S_ADDI_EXEC;
        end else begin
          w_next = S_TRAP;
        end
      end
      S_MEM_ADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALU_ADD;
        w_next           = r_is_sw ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.iord     = 1'b1;
        if (bus.mem_ready) begin
          w_next = S_MEM_WB;
        end else if (w_timeout_c) begin
          w_next  = S_TRAP;
          w_cause = CAUSE_TIMEOUT;
        end
      end
      S_MEM_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_dst    = 1'b0;
        w_ctrl.instr_done = 1'b1;
        w_next            = S_FETCH;
      end
      S_MEM_WR: begin
        w_ctrl.mem_write  = 1'b1;
        w_ctrl.iord       = 1'b1;
        w_ctrl.instr_done = bus.mem_ready;
        if (bus.mem_ready) begin
          w_next = S_FETCH;
        end else if (w_timeout_c) begin
          w_next  = S_TRAP;
          w_cause = CAUSE_TIMEOUT;
        end
      end
      S_R_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_B;
        w_ctrl.alu_op    = ALU_FUNCT;
        w_next           = S_R_WB;
      end
      S_R_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = 1'b1;
        w_ctrl.mem_to_reg = 1'b0;
        w_ctrl.instr_done = 1'b1;
        w_next            = S_FETCH;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_src_b     = SRCB_B;
        w_ctrl.alu_op        = ALU_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = PCSRC_ALUOUT;
        w_ctrl.instr_done    = 1'b1;
`ifdef MCU_BNE_EN
        w_ctrl.branch_ne     = r_is_bne;
`endif
        w_next               = S_FETCH;
      end
      S_JUMP: begin
        w_ctrl.pc_write   = 1'b1;
        w_ctrl.pc_source  = PCSRC_JUMP;
        w_ctrl.instr_done = 1'b1;
        w_next            = S_FETCH;
      end
      S_ADDI_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALU_ADD;
        w_next           = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = 1'b0;
        w_ctrl.mem_to_reg = 1'b0;
        w_ctrl.instr_done = 1'b1;
        w_next            = S_FETCH;
      end
      S_TRAP: begin
        w_ctrl.illegal_op = (r_trap_cause == CAUSE_ILLEGAL);
        w_ctrl.timeout    = (r_trap_cause == CAUSE_TIMEOUT);
        w_next            = S_FETCH;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Reset forces every control low immediately, even before the state register clears.
  assign w_out = rst_n ? w_ctrl : '0;

  assign bus.pc_write      = w_out.pc_write;
  assign bus.pc_write_cond = w_out.pc_write_cond;
  assign bus.iord          = w_out.iord;
  assign bus.mem_read      = w_out.mem_read;
  assign bus.mem_write     = w_out.mem_write;
  assign bus.ir_write      = w_out.ir_write;
  assign bus.reg_dst       = w_out.reg_dst;
  assign bus.mem_to_reg    = w_out.mem_to_reg;
  assign bus.reg_write     = w_out.reg_write;
  assign bus.alu_src_a     = w_out.alu_src_a;
  assign bus.alu_src_b     = w_out.alu_src_b;
  assign bus.alu_op        = w_out.alu_op;
  assign bus.pc_source     = w_out.pc_source;
  assign bus.branch_ne     = w_out.branch_ne;
  assign bus.instr_done    = w_out.instr_done;
  assign bus.illegal_op    = w_out.illegal_op;
  assign bus.timeout       = w_out.timeout;
  assign bus.state         = rst_n ? r_state : S_FETCH;

endmodule
